seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode 7-segment display. It accepts a packed BCD word through a valid/ready load port and double-buffers it so that updates take effect only at frame boundaries. It cycles the digit anodes with a blanking guard interval and drives one shared active-low segment bus through the BCD-to-segment decoder. It sits between the design's numeric datapath and the board display pins.

---
 rtl/seven_seg_pkg.sv | 24 ++
 rtl/seven_seg_scan_ctrl_bcd_to_seg.sv | 26 ++
 rtl/seven_seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package seven_seg_pkg;

   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd_to_seg.sv
// BCD to active-low 7-segment decoder; non-decimal codes render blank.
module bcd_to_seg
   import seven_seg_pkg::*;
(
   input  logic [BCD_W-1:0] i_code,
   output logic [6:0]       o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with a double-buffered
// BCD load port; new values are committed only at frame boundaries.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   output logic                        ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic                        lz_en,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [6:0]                  seg,
   output logic                        dp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
   end

   scan_state_t                  r_state;
   logic [CNT_W-1:0]             r_cnt;
   logic [IDX_W-1:0]             r_idx;
   logic [BCD_W*NUM_DIGITS-1:0]  r_disp_val;
   logic [NUM_DIGITS-1:0]        r_disp_dp;
   logic [BCD_W*NUM_DIGITS-1:0]  r_pend_val;
   logic [NUM_DIGITS-1:0]        r_pend_dp;
   logic                         r_pend_valid;
   logic [NUM_DIGITS-1:0]        r_an;
   logic [6:0]                   r_seg;
   logic                         r_dp;

   scan_state_t                  w_state_nxt;
   logic [CNT_W-1:0]             w_cnt_nxt;
   logic [IDX_W-1:0]             w_idx_nxt;
   logic                         w_commit;
   logic                         w_accept;
   logic [NUM_DIGITS-1:0]        w_upper_zero;
   logic [BCD_W-1:0]             w_digit;
   logic                         w_dp_sel;
   logic                         w_sup_sel;
   logic [NUM_DIGITS-1:0]        w_an_sel;
   logic [6:0]                   w_seg_dec;
   logic [6:0]                   w_seg_show;

   assign ready    = !r_pend_valid;
   assign w_accept = load && !r_pend_valid;
   assign an       = r_an;
   assign seg      = r_seg;
   assign dp       = r_dp;

   // w_upper_zero[i]: digit i and every more-significant digit are zero.
   always_comb begin
      logic run;
      run          = 1'b1;
      w_upper_zero = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         run = run && (r_disp_val[(NUM_DIGITS-1-k)*BCD_W +: BCD_W] == '0);
         w_upper_zero[NUM_DIGITS-1-k] = run;
      end
   end

   always_comb begin
      w_digit   = '0;
      w_dp_sel  = 1'b0;
      w_sup_sel = 1'b0;
      w_an_sel  = '1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_digit     = r_disp_val[k*BCD_W +: BCD_W];
            w_dp_sel    = r_disp_dp[k];
            w_sup_sel   = lz_en && (k != 0) && w_upper_zero[k];
            w_an_sel[k] = 1'b0;
         end
      end
   end

   bcd_to_seg u_dec (
      .i_code (w_digit),
      .o_seg  (w_seg_dec)
   );

   assign w_seg_show = w_sup_sel ? SEG_BLANK : w_seg_dec;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_idx_nxt   = r_idx;
      w_commit    = 1'b0;
      case (r_state)
         BLANK: begin
            if (r_cnt == BLANK_LAST) w_state_nxt = SHOW;
         end
         SHOW: begin
            if (r_cnt == SLOT_LAST) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
               w_commit    = r_pend_valid && (r_idx == IDX_LAST);
            end
         end
         default: w_state_nxt = BLANK;
      endcase
   end

   // Outputs are registered from the next state so the anode and segment
   // buses switch on the same edge as the FSM and never glitch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= BLANK;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_an         <= '1;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_in;
            r_pend_valid <= 1'b1;
         end else if (w_commit) begin
            r_disp_val   <= r_pend_val;
            r_disp_dp    <= r_pend_dp;
            r_pend_valid <= 1'b0;
         end
         if (w_state_nxt == SHOW) begin
            r_an  <= w_an_sel;
            r_seg <= w_seg_show;
            r_dp  <= !w_dp_sel;
         end else begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blanking).
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] SB = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic        ready;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .ready (ready),
      .value (value),
      .dp_in (dp_in),
      .lz_en (lz_en),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   // Waits for a fresh occurrence of the anode pattern (first cycle of that slot's SHOW).
   task automatic wait_an(input logic [3:0] pat, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64 && an === pat; i++) tick();
      for (int i = 0; i < 64; i++) begin
         if (an === pat) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_commit(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 48; i++) begin
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Records {an,seg,dp} at the first SHOW cycle of each digit of one frame.
   task automatic capture_frame(output logic [47:0] obs, output bit ok);
      obs = '1;
      wait_an(4'b1110, ok);
      for (int i = 0; i < ND; i++) begin
         obs[i*12 +: 12] = {an, seg, dp};
         if (i < ND - 1) repeat (RD) tick();
      end
   endtask

   task automatic test_reset();
      logic [11:0] exp_v;
      logic [3:0]  ea;
      int          cnt;
      int          idx;
      rst_n = 1'b0; load = 1'b0; lz_en = 1'b0; value = '0; dp_in = '0;
      tick(); tick();
      n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
      n_tests++; if (seg !== SB) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", seg, SB); end
      n_tests++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
      rst_n = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         tick();
         cnt = c % RD;
         idx = (c / RD) % ND;
         ea  = 4'b1111;
         if (cnt >= BC) ea[idx] = 1'b0;
         exp_v = {ea, (cnt >= BC) ? S0 : SB, 1'b1};
         n_tests++;
         if ({an, seg, dp} !== exp_v)
            begin n_fail++; $display("FAIL scan_cycle%0d: got an=%b seg=%b dp=%b expected %b", c, an, seg, dp, exp_v); end
      end
   endtask

   task automatic test_load();
      logic [47:0] obs;
      logic [27:0] es;
      logic [3:0]  prev_an;
      logic [3:0]  ea;
      bit          ok;
      bit          bad;
      do_load(16'h1234, 4'b0000);
      n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_low: got %b expected 0", ready); end
      ok = 1'b0; bad = 1'b0; prev_an = an;
      for (int i = 0; i < 48; i++) begin
         if (ready === 1'b1) begin ok = 1'b1; break; end
         if (seg !== ((an === 4'b1111) ? SB : S0)) bad = 1'b1;
         prev_an = an;
         tick();
      end
      n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL load_hold: display changed before boundary got 1 expected 0"); end
      n_tests++;
      if ({ok, prev_an, an} !== {1'b1, 4'b0111, 4'b1111})
         begin n_fail++; $display("FAIL load_boundary: got ok=%b prev_an=%b an=%b expected 1 0111 1111", ok, prev_an, an); end
      capture_frame(obs, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL load_capture: timeout got 0 expected 1"); end
      es = {S1, S2, S3, S4};
      for (int i = 0; i < ND; i++) begin
         ea = 4'b1111; ea[i] = 1'b0;
         n_tests++;
         if (obs[i*12 +: 12] !== {ea, es[i*7 +: 7], 1'b1})
            begin n_fail++; $display("FAIL load_digit%0d: got %b expected %b", i, obs[i*12 +: 12], {ea, es[i*7 +: 7], 1'b1}); end
      end
   endtask

   task automatic test_lz();
      logic [47:0] obs;
      logic [27:0] es;
      logic [3:0]  ed;
      logic [3:0]  ea;
      bit          ok;
      lz_en = 1'b1;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) begin do_load(16'h0070, 4'b0000); es = {SB, SB, S7, S0}; ed = 4'b1111; end
         else        begin do_load(16'h0000, 4'b1000); es = {SB, SB, SB, S0}; ed = 4'b0111; end
         wait_commit(ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL lz%0d_commit: timeout got 0 expected 1", t); end
         capture_frame(obs, ok);
         for (int i = 0; i < ND; i++) begin
            ea = 4'b1111; ea[i] = 1'b0;
            n_tests++;
            if (obs[i*12 +: 12] !== {ea, es[i*7 +: 7], ed[i]})
               begin n_fail++; $display("FAIL lz%0d_digit%0d: got %b expected %b", t, i, obs[i*12 +: 12], {ea, es[i*7 +: 7], ed[i]}); end
         end
      end
      lz_en = 1'b0;
   endtask

   task automatic test_blank_code();
      logic [47:0] obs;
      logic [27:0] es;
      logic [3:0]  ed;
      logic [3:0]  ea;
      bit          ok;
      do_load(16'h00A5, 4'b0100);
      wait_commit(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL code_commit: timeout got 0 expected 1"); end
      capture_frame(obs, ok);
      es = {S0, S0, SB, S5};
      ed = 4'b1011;
      for (int i = 0; i < ND; i++) begin
         ea = 4'b1111; ea[i] = 1'b0;
         n_tests++;
         if (obs[i*12 +: 12] !== {ea, es[i*7 +: 7], ed[i]})
            begin n_fail++; $display("FAIL code_digit%0d: got %b expected %b", i, obs[i*12 +: 12], {ea, es[i*7 +: 7], ed[i]}); end
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] obs;
      logic [3:0]  ea;
      bit          ok;
      do_load(16'h1111, 4'b0000);
      n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b expected 0", ready); end
      do_load(16'h5678, 4'b0000);
      n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_still_low: got %b expected 0", ready); end
      wait_commit(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_commit: timeout got 0 expected 1"); end
      capture_frame(obs, ok);
      for (int i = 0; i < ND; i++) begin
         ea = 4'b1111; ea[i] = 1'b0;
         n_tests++;
         if (obs[i*12 +: 12] !== {ea, S1, 1'b1})
            begin n_fail++; $display("FAIL b2b_digit%0d: got %b expected %b", i, obs[i*12 +: 12], {ea, S1, 1'b1}); end
      end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_no_pending: got %b expected 1", ready); end
   endtask

   task automatic test_reset_mid();
      logic [47:0] obs;
      logic [3:0]  ea;
      bit          ok;
      wait_an(4'b1110, ok);
      do_load(16'h9999, 4'b1111);
      n_tests++;
      if ({ok, ready, an} !== {1'b1, 1'b0, 4'b1110})
         begin n_fail++; $display("FAIL rstmid_pre: got ok=%b ready=%b an=%b expected 1 0 1110", ok, ready, an); end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({an, seg, dp, ready} !== {4'b1111, SB, 1'b1, 1'b1})
         begin n_fail++; $display("FAIL rstmid_outputs: got %b expected %b", {an, seg, dp, ready}, {4'b1111, SB, 1'b1, 1'b1}); end
      rst_n = 1'b1;
      tick();
      n_tests++; if (an !== 4'b1111) begin n_fail++; $display("FAIL rstmid_blank: got %b expected 1111", an); end
      tick();
      n_tests++;
      if ({an, seg} !== {4'b1110, S0}) begin n_fail++; $display("FAIL rstmid_first_show: got %b expected %b", {an, seg}, {4'b1110, S0}); end
      for (int f = 0; f < 2; f++) begin
         capture_frame(obs, ok);
         for (int i = 0; i < ND; i++) begin
            ea = 4'b1111; ea[i] = 1'b0;
            n_tests++;
            if (obs[i*12 +: 12] !== {ea, S0, 1'b1})
               begin n_fail++; $display("FAIL rstmid_f%0d_digit%0d: got %b expected %b", f, i, obs[i*12 +: 12], {ea, S0, 1'b1}); end
         end
      end
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_lz();
      test_blank_code();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
